memory_burst: RTL

Wishbone B4 slave RAM, inferred to block RAM, successor to the single-cycle Wishbone memory. Adds configurable first-beat wait states, registered-feedback incrementing bursts (linear and wrap-4/8/16), and error responses for misaligned or out-of-range beats. Sits on the SoC Wishbone interconnect as instruction/data memory and supports cache line refills via bursts.

---
 rtl/memory_burst_if.sv | 26 ++
 rtl/memory_burst.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/memory_burst_if.sv
// Wishbone B4 slave bus bundle for memory_burst: request signals from the master
// and ack/err/rty/data back from the slave.
interface memory_burst_if;
  logic        cyc_i;
  logic        stb_i;
  logic [31:0] adr_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  modport slave (
    input  cyc_i, stb_i, adr_i, we_i, sel_i, dat_i, cti_i, bte_i,
    output dat_o, ack_o, err_o, rty_o
  );

  modport master (
    output cyc_i, stb_i, adr_i, we_i, sel_i, dat_i, cti_i, bte_i,
    input  dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/memory_burst.sv
// Wishbone B4 block-RAM slave with first-beat wait states, registered-feedback
// incrementing bursts (linear, wrap-4/8/16) and err responses for bad beats.
module memory_burst #(
  parameter logic [31:0] BASE_ADDRESS  = 32'h0000_0000,
  parameter int unsigned SIZE          = 4096,
  parameter int unsigned WAIT_STATES   = 0,
  parameter string       READMEMH_FILE = ""
) (
  input logic          clk_i,
  input logic          rst_i,
  memory_burst_if.slave wb
);

  localparam int unsigned DEPTH = SIZE / 4;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW    = AW + 1;  // one spare bit so index == DEPTH is representable

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_BURST
  } state_e;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] data_q;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          we_q, we_d;
  logic          burst_q, burst_d;
  logic          err_q, err_d;
  logic          rdy_q, rdy_d;
  logic [3:0]    wcnt_q, wcnt_d;

  logic [31:0]   offset_c;
  logic          addressed_c;
  logic          misalign_c;
  logic          req_c;
  logic          done_c;
  logic          ack_c;
  logic [IW-1:0] wrap_mask_c;
  logic [IW-1:0] nxt_idx_c;
  logic          nxt_oob_c;
  logic          rd_en_c;
  logic [AW-1:0] rd_idx_c;
  logic          wr_en_c;

  // Address decode of the incoming request.
  always_comb begin
    offset_c    = wb.adr_i - BASE_ADDRESS;
    addressed_c = (wb.adr_i >= BASE_ADDRESS) && (offset_c < SIZE);
    misalign_c  = (wb.adr_i[1:0] != 2'b00);
    req_c       = wb.cyc_i && wb.stb_i && addressed_c;
  end

  // Next burst index: wrap modes only advance the low log2(N) bits.
  always_comb begin
    case (wb.bte_i)
      2'b01:   wrap_mask_c = IW'(3);
      2'b10:   wrap_mask_c = IW'(7);
      2'b11:   wrap_mask_c = IW'(15);
      default: wrap_mask_c = '1;
    endcase
    nxt_idx_c = (idx_q & ~wrap_mask_c) | ((idx_q + IW'(1)) & wrap_mask_c);
    nxt_oob_c = (nxt_idx_c >= IW'(DEPTH));
  end

  assign done_c = rdy_q && wb.cyc_i && wb.stb_i;
  assign ack_c  = done_c && !err_q;

  // Next-state and RAM port control.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    we_d     = we_q;
    burst_d  = burst_q;
    err_d    = err_q;
    rdy_d    = rdy_q;
    wcnt_d   = wcnt_q;
    rd_en_c  = 1'b0;
    rd_idx_c = idx_q[AW-1:0];
    wr_en_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          idx_d    = IW'(offset_c >> 2);
          we_d     = wb.we_i;
          burst_d  = (wb.cti_i == 3'b010);
          err_d    = misalign_c;
          rd_idx_c = AW'(offset_c >> 2);
          if (misalign_c || (WAIT_STATES == 0)) begin
            state_d = S_RESP;
            rdy_d   = 1'b1;
            rd_en_c = !wb.we_i;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = 4'(WAIT_STATES);
          end
        end
      end

      S_WAIT: begin
        if (!wb.cyc_i) begin
          state_d = S_IDLE;
          rdy_d   = 1'b0;
          wcnt_d  = 4'd0;
        end else if (wcnt_q <= 4'd1) begin
          state_d = S_RESP;
          rdy_d   = 1'b1;
          wcnt_d  = 4'd0;
          rd_en_c = !we_q;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end

      S_RESP, S_BURST: begin
        if (!wb.cyc_i) begin
          state_d = S_IDLE;
          rdy_d   = 1'b0;
        end else if (done_c) begin
          wr_en_c = we_q && !err_q;
          if (burst_q && (wb.cti_i != 3'b111) && !err_q) begin
            // Prefetch the next beat on the completion edge for one beat per cycle.
            state_d  = S_BURST;
            idx_d    = nxt_idx_c;
            err_d    = nxt_oob_c;
            rd_idx_c = nxt_idx_c[AW-1:0];
            rd_en_c  = !we_q && !nxt_oob_c;
          end else begin
            state_d = S_IDLE;
            rdy_d   = 1'b0;
          end
        end
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Block RAM: byte-lane write port and registered read port, contents not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_c && !rst_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.sel_i[b]) mem_q[idx_q[AW-1:0]][8*b +: 8] <= wb.dat_i[8*b +: 8];
      end
    end
    if (rd_en_c) data_q <= mem_q[rd_idx_c];
  end

  assign wb.ack_o = ack_c;
  assign wb.err_o = done_c && err_q;
  assign wb.rty_o = 1'b0;
  assign wb.dat_o = ack_c ? data_q : 'z;

endmodule
